// File: rtl/wave_synth.sv
// wave_synth: multi-channel DDS synthesiser. A tick divider feeds a five-stage pipeline (acc, A, B, C, D).
// Define WAVE_SYNTH_SINE_EN to compile the quarter-wave sine LUT; without it mode 0 plays triangle.
module wave_synth #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 16,
   parameter int SAMP_W   = 12,
   parameter int DIV_W    = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sync_clear,
   input  logic [DIV_W-1:0]           div,
   input  logic [CHANNELS*SAMP_W-1:0] amp,
   input  logic [CHANNELS*ACC_W-1:0]  phase_off,
   input  logic [CHANNELS*ACC_W-1:0]  phase_inc,
   input  logic [CHANNELS*2-1:0]      mode,
   output logic                       tick,
   output logic                       valid,
   output logic [SAMP_W-1:0]          result
);
   localparam int PROD_W = 2 * SAMP_W;
   localparam int SUM_W  = SAMP_W + 4;
   localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << SAMP_W) - 1);

`ifdef WAVE_SYNTH_SINE_EN
   typedef logic [10:0] lut_t [256];

   // Quarter-wave magnitude table, sampled at bin centres so the quarter folds symmetrically.
   function automatic lut_t build_lut();
      lut_t t;
      for (int i = 0; i < 256; i++)
         t[i] = 11'($rtoi(2047.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 512.0) + 0.5));
      return t;
   endfunction

   localparam lut_t SINE_LUT = build_lut();
`endif

   // Every shape is built as a 16-bit full-scale word and then top-aligned to SAMP_W.
   function automatic logic [SAMP_W-1:0] shape(input logic [15:0] p, input logic [1:0] m);
      logic [15:0] w;
`ifdef WAVE_SYNTH_SINE_EN
      logic [7:0]  q;
      logic [11:0] s;
`endif
      case (m)
         2'd1: w = p[15] ? 16'h0000 : 16'hffff;
         2'd2: w = p;
`ifdef WAVE_SYNTH_SINE_EN
         2'd0: begin
            q = p[14] ? ~p[13:6] : p[13:6];
            s = p[15] ? 12'd2048 - {1'b0, SINE_LUT[q]} : 12'd2048 + {1'b0, SINE_LUT[q]};
            w = {s, 4'h0};
         end
`endif
         default: w = p[15] ? {~p[14:0], 1'b1} : {p[14:0], 1'b0};
      endcase
      return w[15 -: SAMP_W];
   endfunction

   logic [DIV_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc      [CHANNELS];
   logic [ACC_W-1:0]  p_full   [CHANNELS];
   logic [15:0]       p_a      [CHANNELS];
   logic [SAMP_W-1:0] raw_b    [CHANNELS];
   logic [SAMP_W-1:0] scaled_c [CHANNELS];
   logic              v_acc, v_a, v_b, v_c;
   logic [SUM_W-1:0]  sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (sync_clear) begin
         cnt  <= div;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= div;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - 1'b1;
         tick <= 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++)
         p_full[i] = acc[i] + phase_off[i*ACC_W +: ACC_W];
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < CHANNELS; i++)
         sum = sum + SUM_W'(scaled_c[i]);
   end

   // Data stages run freely; only the valid chain marks which beats carry a real sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i]      <= '0;
            p_a[i]      <= '0;
            raw_b[i]    <= '0;
            scaled_c[i] <= '0;
         end
         v_acc  <= 1'b0;
         v_a    <= 1'b0;
         v_b    <= 1'b0;
         v_c    <= 1'b0;
         valid  <= 1'b0;
         result <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync_clear)
               acc[i] <= '0;
            else if (tick)
               acc[i] <= acc[i] + phase_inc[i*ACC_W +: ACC_W];
            p_a[i]      <= p_full[i][ACC_W-1 -: 16];
            raw_b[i]    <= shape(p_a[i], mode[i*2 +: 2]);
            scaled_c[i] <= SAMP_W'((PROD_W'(raw_b[i]) * PROD_W'(amp[i*SAMP_W +: SAMP_W])) >> SAMP_W);
         end
         v_acc <= tick & ~sync_clear;
         v_a   <= v_acc & ~sync_clear;
         v_b   <= v_a & ~sync_clear;
         v_c   <= v_b & ~sync_clear;
         valid <= v_c & ~sync_clear;
         if (sync_clear)
            result <= '0;
         else if (v_c)
            result <= (sum > SAT) ? SAT[SAMP_W-1:0] : sum[SAMP_W-1:0];
      end
   end
endmodule

// File: doc/wave_synth.md
# wave_synth

Parametrised multi-channel DDS waveform synthesiser; successor to the single-channel sine path behind the host wire endpoints. A programmable tick divider sets the sample rate, and each channel runs its own phase accumulator, waveform mode, phase offset and amplitude. Channel outputs are summed with saturation into one unsigned sample that feeds the wire-out and LED path.

## Interface
Parameters:
- CHANNELS, 2, number of synthesis channels (1..8)
- ACC_W, 16, phase accumulator / offset / increment width (≥16)
- SAMP_W, 12, sample and amplitude width
- DIV_W, 16, tick divider width

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- sync_clear  in  1  synchronous restart (host control bit)
- div  in  DIV_W  tick reload value; tick period = div+1 clocks
- amp  in  CHANNELS*SAMP_W  per-channel amplitude, channel i at [i*SAMP_W +: SAMP_W]
- phase_off  in  CHANNELS*ACC_W  per-channel phase offset
- phase_inc  in  CHANNELS*ACC_W  per-channel phase increment per tick
- mode  in  CHANNELS*2  per-channel waveform: 0 sine, 1 square, 2 saw, 3 triangle
- tick  out  1  registered sample strobe, one cycle wide
- valid  out  1  one-cycle pulse when result updates
- result  out  SAMP_W  summed, saturated sample; holds between valid pulses

## Operation
- Divider: counter cnt. If sync_clear: cnt<=div, tick<=0. Else if cnt==0: cnt<=div, tick<=1. Else cnt<=cnt-1, tick<=0. A new div takes effect at the next reload.
- Accumulator: on each edge with tick==1 and !sync_clear, acc[i] <= acc[i]+phase_inc[i] mod 2^ACC_W.
- Stage A: p = acc+phase_off mod 2^ACC_W. Only the top 16 bits, p[15:0] below, are used.
- Stage B raw (SAMP_W=12 shown; generally top-aligned):
  - square: p[15] ? 0 : 4095
  - saw: p[15:4]
  - triangle: p[15] ? ~p[14:3] : p[14:3]
  - sine: q = p[14] ? ~p[13:6] : p[13:6]; mag = LUT[q], with LUT[i] = round(2047*sin(π/2*(i+0.5)/256)); raw = p[15] ? 2048-mag : 2048+mag
- Stage C: scaled = (raw*amp) >> SAMP_W, full-width product, truncating.
- Stage D: sum of all channels' scaled values, saturated to 2^SAMP_W-1. It loads result and pulses valid only when the delayed tick reaches this stage.
- Priority: sync_clear does the following and overrides a coincident tick:
  - zeroes all accumulators
  - flushes the valid pipeline
  - clears result to 0
  - reloads the divider
- Config inputs are sampled live at each stage. A change between ticks affects only samples whose strobe has not yet passed that stage.

## Timing
- Reset (reset_n low, asynchronous) sets:
  - cnt=0, acc=0, all pipeline registers=0
  - tick=0, valid=0, result=0
- First tick is asserted in the first cycle after the first edge following reset release.
- Latency: tick high in cycle k → valid high and new result in cycle k+5: acc, A, B, C, D, one stage per edge.
- div=0: tick every cycle. The pipeline is fully pipelined, so valid also comes every cycle.
- Accumulator wrap is silent modulo 2^ACC_W. phase_inc=0 gives a constant output.
- sync_clear held high: no tick, no valid, result=0. After release, the first tick comes div+1 cycles later.

## Configuration
- WAVE_SYNTH_SINE_EN defined: the quarter-wave LUT (256×11) is compiled in, and mode 0 = sine.
- Undefined: no LUT, and mode 0 decodes identically to triangle (mode 3). All other behaviour and latency are unchanged.

## Test plan
- Saw: reset, CHANNELS=2, div=3, ch0 mode 2, amp 4095, inc 0x1000, off 0; ch1 amp 0. Required:
  - tick every 4 cycles, valid exactly 5 cycles after each tick
  - results 255, 511, 767 … 3839, then 0 on the 16th sample (wrap)
- Square saturation: both channels mode 1, amp 4095, inc 0x8000, off 0. Required: results alternate 0, 4095 (4094+4094 saturated).
- Sine: mode 0, amp 4095, inc 0x4000, off 0, first sample.
  - SINE_EN defined: result 4094
  - Undefined: result 2047 (triangle)
- Phase offset: mode 2, inc 0, off 0x8000, amp 4095. Required: every valid gives 2047.
- sync_clear: assert for 3 cycles during the saw run, coincident with a tick. Required:
  - no valid for ≥5 cycles, result=0
  - restart sequence begins at 255, first tick div+1 cycles after release
- Async reset: drop reset_n mid-cycle during the run. Required: tick, valid and result go to 0 immediately, without waiting for a clock edge; after release, the saw sequence restarts from 255.
